matmul_host_sequencer: RTL and testbench

Host-side sequencer in front of `matrix_multiplication`. It loads matrix A and matrix B row-words into the block's RAMs through the shared `data_pi`/`addr_pi` port, runs one multiply via `start_mat_mul`/`done_mat_mul`, then reads matrix C back out. Input and output are valid/ready streams of full row-words. It replaces the bench-driven loading of the matmul top level.

---
 rtl/matmul_host_sequencer_if.sv | 43 ++++
 rtl/matmul_host_sequencer.sv | 154 +++++++++++++++
 tb/tb_matmul_host_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_host_sequencer_if.sv
// Stream and RAM-port bundle between matmul_host_sequencer (master) and the
// host streams plus matrix_multiplication block (slave).
interface matmul_host_sequencer_if #(
    parameter int DWIDTH       = 16,
    parameter int MAT_MUL_SIZE = 16,
    parameter int AWIDTH       = 7
) ();
    localparam int W = MAT_MUL_SIZE * DWIDTH;

    logic              cmd_start;
    logic              busy;
    logic              job_done;
    logic [W-1:0]      in_data;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              enable_writing_to_mem;
    logic              enable_reading_from_mem;
    logic [AWIDTH-1:0] addr_pi;
    logic [W-1:0]      data_pi;
    logic              we_a;
    logic              we_b;
    logic              we_c;
    logic              start_mat_mul;
    logic              done_mat_mul;
    logic [W-1:0]      data_from_out_mat;

    modport master (
        input  cmd_start, in_data, in_valid, out_ready, done_mat_mul, data_from_out_mat,
        output busy, job_done, in_ready, out_data, out_valid,
               enable_writing_to_mem, enable_reading_from_mem,
               addr_pi, data_pi, we_a, we_b, we_c, start_mat_mul
    );

    modport slave (
        output cmd_start, in_data, in_valid, out_ready, done_mat_mul, data_from_out_mat,
        input  busy, job_done, in_ready, out_data, out_valid,
               enable_writing_to_mem, enable_reading_from_mem,
               addr_pi, data_pi, we_a, we_b, we_c, start_mat_mul
    );
endinterface

// File: rtl/matmul_host_sequencer.sv
// Loads A and B into matrix_multiplication, runs one multiply, then streams C
// back out through a credit-controlled 4-entry FIFO.
module matmul_host_sequencer #(
    parameter int ROWS         = 16,
    parameter int DWIDTH       = 16,
    parameter int MAT_MUL_SIZE = 16,
    parameter int AWIDTH       = 7
) (
    input logic                    clk,
    input logic                    reset,
    matmul_host_sequencer_if.master bus
);
    localparam int W = MAT_MUL_SIZE * DWIDTH;

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, WR_DRAIN, COMPUTE, READ_C, RD_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d, addr_next;
    logic [1:0]        drain_q, drain_d;
    logic [2:0]        credits_q, credits_d;
    logic [2:0]        tag_q;
    logic              done_d;

    logic              wl_vld_q, wl_b_q;
    logic [W-1:0]      wl_data_q, data_pi_q;
    logic              we_a_q, we_b_q, we_c_q, start_q;
    logic              en_wr_q, en_rd_q, in_ready_q, busy_q, job_done_q;

    logic [W-1:0]      fifo_mem [4];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q;

    logic accept, issue, push, pop, addr_last;

    assign accept    = in_ready_q && bus.in_valid;
    assign push      = tag_q[2];
    assign pop       = (count_q != 3'd0) && bus.out_ready;
    // A pop in the same cycle frees a slot, so a read may issue on zero credits.
    assign issue     = (state_q == READ_C) && ((credits_q != 3'd0) || pop);
    assign addr_last = (addr_q == AWIDTH'(ROWS - 1));
    assign addr_next = addr_last ? '0 : addr_q + 1'b1;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_start) begin
                state_d = LOAD_A;
                addr_d  = '0;
            end
            LOAD_A: if (accept) begin
                addr_d = addr_next;
                if (addr_last) state_d = LOAD_B;
            end
            LOAD_B: if (accept) begin
                addr_d = addr_next;
                if (addr_last) begin
                    state_d = WR_DRAIN;
                    drain_d = '0;
                end
            end
            WR_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd3) state_d = COMPUTE;
            end
            COMPUTE: if (bus.done_mat_mul) state_d = READ_C;
            READ_C: if (issue) begin
                addr_d = addr_next;
                if (addr_last) state_d = RD_DRAIN;
            end
            RD_DRAIN: if (pop && count_q == 3'd1 && tag_q == 3'b000) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        credits_d = credits_q - {2'b00, issue} + {2'b00, pop};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            drain_q    <= '0;
            credits_q  <= 3'd4;
            tag_q      <= '0;
            wl_vld_q   <= 1'b0;
            wl_b_q     <= 1'b0;
            wl_data_q  <= '0;
            data_pi_q  <= '0;
            we_a_q     <= 1'b0;
            we_b_q     <= 1'b0;
            we_c_q     <= 1'b0;
            start_q    <= 1'b0;
            en_wr_q    <= 1'b0;
            en_rd_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            job_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            credits_q  <= credits_d;
            tag_q      <= {tag_q[1:0], issue};
            // Two-stage write line mirrors the two address registers inside matmul.
            wl_vld_q   <= accept;
            wl_b_q     <= (state_q == LOAD_B);
            if (accept) wl_data_q <= bus.in_data;
            we_a_q     <= wl_vld_q && !wl_b_q;
            we_b_q     <= wl_vld_q && wl_b_q;
            if (wl_vld_q) data_pi_q <= wl_data_q;
            in_ready_q <= (state_d == LOAD_A) || (state_d == LOAD_B);
            en_wr_q    <= (state_d == LOAD_A) || (state_d == LOAD_B) ||
                          ((state_d == WR_DRAIN) && (drain_d < 2'd2));
            start_q    <= (state_d == COMPUTE);
            we_c_q     <= (state_d == COMPUTE);
            en_rd_q    <= (state_d == READ_C) || (state_d == RD_DRAIN);
            busy_q     <= (state_d != IDLE);
            job_done_q <= done_d;
            wr_ptr_q   <= wr_ptr_q + {1'b0, push};
            rd_ptr_q   <= rd_ptr_q + {1'b0, pop};
            count_q    <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    // NOTE: FIFO storage is not reset; the cleared count masks stale entries.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.data_from_out_mat;
    end

    assign bus.busy                    = busy_q;
    assign bus.job_done                = job_done_q;
    assign bus.in_ready                = in_ready_q;
    assign bus.out_valid               = (count_q != 3'd0);
    assign bus.out_data                = (count_q != 3'd0) ? fifo_mem[rd_ptr_q] : '0;
    assign bus.enable_writing_to_mem   = en_wr_q;
    assign bus.enable_reading_from_mem = en_rd_q;
    assign bus.addr_pi                 = addr_q;
    assign bus.data_pi                 = data_pi_q;
    assign bus.we_a                    = we_a_q;
    assign bus.we_b                    = we_b_q;
    assign bus.we_c                    = we_c_q;
    assign bus.start_mat_mul           = start_q;
endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Self-checking bench: stubs matrix_multiplication around the sequencer and
// compares every C row against a plain-arithmetic matrix product of the sent rows.
module tb_matmul_host_sequencer;
    typedef logic [255:0] word_t;
    typedef word_t mat_t [16];
    typedef struct {
        int    cyc;
        int    row;
        bit    is_b;
        word_t data;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matmul_host_sequencer_if bus ();
    matmul_host_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    word_t src [32];
    mat_t  exp_c, a_stub, b_stub, c_stub;
    beat_t beats [$];
    logic [6:0] addr_hist [4];

    int cyc, src_idx, rows_out, wa_cnt, wb_cnt, done_cnt, rd_issued;
    int start_cycles, wec_cycles, start_run, done_delay;
    int first_ready_cyc, last_accept_cyc, rd_entry_cyc, first_ov_cyc, last_pop_cyc;
    int stall_at, stall_len, stall_left;
    bit in_toggle, tog, pulse_cmd, start_req, reset_req, prev_en_rd, hold_pending;
    word_t hold_data;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // C = A x B over 16-bit elements, element j of a row at bits [16j +: 16].
    function automatic mat_t matmul(input mat_t a, input mat_t b);
        mat_t c;
        logic [15:0] acc;
        for (int i = 0; i < 16; i++) begin
            c[i] = '0;
            for (int j = 0; j < 16; j++) begin
                acc = '0;
                for (int k = 0; k < 16; k++)
                    acc = acc + a[i][k*16 +: 16] * b[k][j*16 +: 16];
                c[i][j*16 +: 16] = acc;
            end
        end
        return c;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic set_expected();
        mat_t a, b;
        for (int i = 0; i < 16; i++) begin
            a[i] = src[i];
            b[i] = src[16 + i];
        end
        exp_c = matmul(a, b);
    endtask

    task automatic prep_identity_ramp();
        for (int i = 0; i < 16; i++) begin
            src[i] = '0;
            src[i][i*16 +: 16] = 16'd1;
            for (int j = 0; j < 16; j++) src[16 + i][j*16 +: 16] = 16'(i * 16 + j);
        end
        set_expected();
    endtask

    task automatic prep_random();
        for (int i = 0; i < 32; i++) src[i] = rand_word();
        set_expected();
    endtask

    task automatic job_init();
        src_idx = 0; rows_out = 0; wa_cnt = 0; wb_cnt = 0; done_cnt = 0; rd_issued = 0;
        start_cycles = 0; wec_cycles = 0; stall_left = 0; tog = 1'b1; hold_pending = 1'b0;
        first_ready_cyc = -1; rd_entry_cyc = -1; first_ov_cyc = -1;
        beats.delete();
    endtask

    // One clock: observe outputs at the falling edge, model the matmul block, drive inputs.
    task automatic step();
        beat_t b;
        bit pulse_now;
        @(negedge clk);
        cyc++;
        pulse_now = 1'b0;
        addr_hist[3] = addr_hist[2];
        addr_hist[2] = addr_hist[1];
        addr_hist[1] = addr_hist[0];
        addr_hist[0] = bus.addr_pi;

        if (bus.we_a || bus.we_b) begin
            check("we_exclusive", {bus.we_a, bus.we_b} != 2'b11, 1);
            check("we_needs_enable", bus.enable_writing_to_mem, 1);
            check("we_has_beat", beats.size() != 0, 1);
            if (beats.size() != 0) begin
                b = beats.pop_front();
                check("we_lag", cyc - b.cyc, 2);
                check("we_matrix_b", bus.we_b, b.is_b);
                check("we_addr", addr_hist[2], b.row);
                check("we_data", bus.data_pi, b.data);
            end
            if (bus.we_a) begin a_stub[addr_hist[2][3:0]] = bus.data_pi; wa_cnt++; end
            else          begin b_stub[addr_hist[2][3:0]] = bus.data_pi; wb_cnt++; end
        end

        check("we_c_tracks_start", bus.we_c, bus.start_mat_mul);
        bus.done_mat_mul = 1'b0;
        if (bus.start_mat_mul) begin
            if (start_run == 0) c_stub = matmul(a_stub, b_stub);
            bus.done_mat_mul = (start_run == done_delay);
            pulse_now = pulse_cmd && (start_run == 2);
            start_run++;
            start_cycles++;
        end else begin
            start_run = 0;
        end
        if (bus.we_c) wec_cycles++;

        bus.data_from_out_mat = c_stub[addr_hist[3][3:0]];
        if (prev_en_rd && addr_hist[0] != addr_hist[1]) rd_issued++;
        if (bus.enable_reading_from_mem) begin
            if (!prev_en_rd) rd_entry_cyc = cyc;
            check("outstanding_le4", (rd_issued - rows_out) <= 4, 1);
        end
        prev_en_rd = bus.enable_reading_from_mem;

        if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
        end else if (stall_len > 0 && rows_out == stall_at && bus.out_valid) begin
            bus.out_ready = 1'b0;
            stall_left = stall_len - 1;
            stall_len = 0;
        end else begin
            bus.out_ready = 1'b1;
        end
        if (hold_pending) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, hold_data);
        end
        hold_pending = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
            if (rows_out < 16) check("c_row", bus.out_data, exp_c[rows_out]);
            else               check("c_extra_row", rows_out, 15);
            rows_out++;
            last_pop_cyc = cyc;
        end

        if (bus.job_done) begin
            done_cnt++;
            check("done_after_all_rows", rows_out, 16);
            check("busy_low_at_done", bus.busy, 0);
        end

        bus.in_valid = !reset_req && (src_idx < 32) && (!in_toggle || tog);
        tog = !tog;
        bus.in_data = bus.in_valid ? src[src_idx] : rand_word();
        if (bus.in_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
        if (bus.in_ready && bus.in_valid) begin
            b.cyc = cyc;
            b.row = src_idx % 16;
            b.is_b = (src_idx >= 16);
            b.data = src[src_idx];
            beats.push_back(b);
            last_accept_cyc = cyc;
            src_idx++;
        end
        bus.cmd_start = start_req || pulse_now;
        start_req = 1'b0;
        reset = reset_req;
        reset_req = 1'b0;
    endtask

    task automatic run_job(input int dd, input bit toggle, input int st_at, input int st_len,
                           input bit pulse, input bit check_rate);
        job_init();
        done_delay = dd; in_toggle = toggle; stall_at = st_at; stall_len = st_len;
        pulse_cmd = pulse;
        start_req = 1'b1;
        step();
        check("in_ready_idle", bus.in_ready, 0);
        step();
        check("in_ready_latency", bus.in_ready, 1);
        for (int i = 0; i < 1000 && done_cnt == 0; i++) step();
        check("job_done_seen", done_cnt, 1);
        check("rows_out", rows_out, 16);
        check("we_a_count", wa_cnt, 16);
        check("we_b_count", wb_cnt, 16);
        check("reads_issued", rd_issued, 16);
        check("start_cycles", start_cycles, dd + 1);
        check("we_c_cycles", wec_cycles, dd + 1);
        if (check_rate) begin
            check("load_rate", last_accept_cyc - first_ready_cyc, 31);
            check("first_out_latency", first_ov_cyc - rd_entry_cyc, 4);
            check("readout_rate", last_pop_cyc - first_ov_cyc, 15);
        end
        pulse_cmd = 1'b0;
    endtask

    task automatic abort_in_load_b();
        prep_random();
        job_init();
        in_toggle = 1'b0; stall_len = 0; done_delay = 0;
        start_req = 1'b1;
        step();
        for (int i = 0; i < 200 && src_idx < 22; i++) step();
        check("reached_load_b", src_idx >= 22, 1);
        reset_req = 1'b1;
        step();
        beats.delete();
        step();
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_en_wr", bus.enable_writing_to_mem, 0);
        check("abort_we_a", bus.we_a, 0);
        check("abort_we_b", bus.we_b, 0);
        check("abort_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        cyc = 0; start_run = 0; prev_en_rd = 1'b0; start_req = 1'b0; reset_req = 1'b0;
        pulse_cmd = 1'b0; stall_len = 0; stall_left = 0; done_delay = 0;
        for (int i = 0; i < 4; i++) addr_hist[i] = '0;
        for (int i = 0; i < 16; i++) begin a_stub[i] = '0; b_stub[i] = '0; c_stub[i] = '0; end
        bus.cmd_start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.done_mat_mul = 1'b0; bus.data_from_out_mat = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_job_done", bus.job_done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_en_wr", bus.enable_writing_to_mem, 0);
        check("rst_en_rd", bus.enable_reading_from_mem, 0);
        check("rst_addr_pi", bus.addr_pi, 0);
        check("rst_data_pi", bus.data_pi, 0);
        check("rst_we", {bus.we_a, bus.we_b, bus.we_c}, 0);
        check("rst_start", bus.start_mat_mul, 0);
        reset = 1'b0;

        // Identity x ramp at full rate: C must equal B.
        prep_identity_ramp();
        check("identity_gives_b", exp_c[7], src[23]);
        run_job(3, 1'b0, 0, 0, 1'b0, 1'b1);
        step();
        check("job_done_single_pulse", bus.job_done, 0);
        check("busy_low_after_job", bus.busy, 0);

        // Bubbled input, done one cycle after start rises.
        prep_random();
        run_job(1, 1'b1, 0, 0, 1'b0, 1'b0);

        // Ten-cycle output stall mid-readout, stray cmd_start during COMPUTE.
        prep_random();
        run_job(5, 1'b0, 5, 10, 1'b1, 1'b0);
        repeat (3) step();
        check("stray_cmd_ignored", bus.busy, 0);
        check("stray_cmd_no_done", done_cnt, 1);

        // Reset during LOAD_B, then a clean job with done on COMPUTE entry.
        abort_in_load_b();
        prep_random();
        run_job(0, 1'b0, 0, 0, 1'b0, 1'b1);

        // Back-to-back jobs: the second cmd_start lands the cycle after job_done.
        prep_random();
        run_job(2, 1'b0, 0, 0, 1'b0, 1'b0);
        prep_random();
        run_job(1, 1'b1, 3, 4, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
